// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter chain: sample width, sample type
// and a constant ceil(log2) helper used to size counters and accumulators.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int unsigned value);
    int unsigned p;
    int          r;
    p = 1;
    r = 0;
    while (p < value) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_skid_fifo2.sv
// Two-entry valid/ready FIFO. The head register drives the output directly.
// A push and a pop in the same cycle at count 1 replace the head in place.
module fir_skid_fifo2
  import fir_pkg::*;
#(
  parameter int DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic [1:0]    count,
  output logic [DW-1:0] head,
  output logic          head_valid
);

  logic [DW-1:0] tail;
  logic          pop;
  logic          do_push;

  assign head_valid = (count != 2'd0);
  assign pop        = head_valid && pop_ready;
  assign do_push    = push && (count != 2'd2);

  // Storage and occupancy; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (do_push) begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push && pop) begin
            head <= push_data;
          end else if (do_push) begin
            tail  <= push_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Decimate-by-DECIM stage with a 2-entry output FIFO.
// Default: pick mode, keeps the sample at index PHASE of each group.
// Define FIR_DECIM_ACC_DUMP_EN for boxcar mode: each group is summed,
// rounded half up, divided by DECIM (power of two) and saturated.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int PHASE = 0,
  parameter int DW    = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          phase_clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_sample,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sample
);

  localparam int           LW       = clog2(DECIM);
  localparam int           PW       = (LW > 0) ? LW : 1;
  localparam logic [PW-1:0] LAST    = PW'(DECIM - 1);
  localparam logic [PW-1:0] KEEP_PH = PW'(PHASE);
  localparam bit           KEEP_ALL = (DECIM == 1);

  logic [PW-1:0] phase;
  logic          rdy_en;
  logic [1:0]    count;
  logic          accept;
  logic          last;
  logic          push;
  logic [DW-1:0] push_data;

  // in_ready comes from registers only; rdy_en holds it low until the
  // first edge after reset release.
  assign in_ready = rdy_en && (count != 2'd2);
  assign accept   = in_valid && in_ready;
  assign last     = (phase == LAST);

  // Phase counter over each group of DECIM accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (phase_clr) begin
        phase <= '0;
      end else if (accept) begin
        phase <= last ? '0 : phase + 1'b1;
      end
    end
  end

`ifdef FIR_DECIM_ACC_DUMP_EN
  localparam int AW = DW + LW;
  localparam logic signed [AW:0] HALF = (AW+1)'((1 << LW) >> 1);
  localparam logic signed [AW:0] MAXV = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  if ((1 << LW) != DECIM) begin : g_bad_decim
    $error("fir_decimator: DECIM must be a power of two in boxcar mode");
  end

  logic signed [AW-1:0] acc;
  logic signed [AW:0]   sum;
  logic signed [AW:0]   shifted;

  // Running group sum, rounded divide and saturation of the dumped value.
  always_comb begin
    sum       = {acc[AW-1], acc} + {{(AW+1-DW){in_sample[DW-1]}}, in_sample};
    shifted   = (sum + HALF) >>> LW;
    push_data = shifted[DW-1:0];
    if (shifted > MAXV) begin
      push_data = MAXV[DW-1:0];
    end else if (shifted < MINV) begin
      push_data = MINV[DW-1:0];
    end
  end

  assign push = accept && last && !phase_clr;

  // Accumulator, cleared at each group boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (phase_clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last ? '0 : sum[AW-1:0];
    end
  end
`else
  assign push      = accept && (KEEP_ALL || (phase == KEEP_PH));
  assign push_data = in_sample;
`endif

  fir_skid_fifo2 #(
    .DW(DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (phase_clr),
    .push      (push),
    .push_data (push_data),
    .pop_ready (out_ready),
    .count     (count),
    .head      (out_sample),
    .head_valid(out_valid)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: a DECIM=4/PHASE=1 instance and a
// DECIM=1 instance sharing clock and reset.
`timescale 1ns/1ps
module tb_fir_decimator;
  import fir_pkg::*;

  logic        clk;
  logic        rst;

  logic        clr4, v4, rdy4, ov4, or4;
  sample_t     s4;
  logic [15:0] o4;

  logic        clr1, v1, rdy1, ov1, or1;
  sample_t     s1;
  logic [15:0] o1;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  fir_decimator #(.DECIM(4), .PHASE(1), .DW(16)) dut4 (
    .clk(clk), .rst(rst), .phase_clr(clr4), .in_valid(v4), .in_sample(s4),
    .in_ready(rdy4), .out_valid(ov4), .out_ready(or4), .out_sample(o4)
  );

  fir_decimator #(.DECIM(1), .PHASE(0), .DW(16)) dut1 (
    .clk(clk), .rst(rst), .phase_clr(clr1), .in_valid(v1), .in_sample(s1),
    .in_ready(rdy1), .out_valid(ov1), .out_ready(or1), .out_sample(o1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input int value);
    v4 = 1'b1;
    s4 = sample_t'(value);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clr4 = 1'b0; v4 = 1'b0; s4 = '0; or4 = 1'b0;
    clr1 = 1'b0; v1 = 1'b0; s1 = '0; or1 = 1'b0;
    exp_last = 16'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov4", ov4, 1'b0);
    chk("rst_o4", o4, 16'd0);
    chk("rst_rdy4", rdy4, 1'b0);
    chk("rst_rdy1", rdy1, 1'b0);
    rst = 1'b1;
    #1;
    chk("rel_rdy4_low", rdy4, 1'b0);
    tick();
    chk("rel_rdy4_high", rdy4, 1'b1);
    chk("rel_rdy1_high", rdy1, 1'b1);

`ifdef FIR_DECIM_ACC_DUMP_EN
    // Boxcar groups
    or4 = 1'b1;
    feed4(1);
    chk("acc_g1_v0", ov4, 1'b0);
    feed4(2);
    feed4(3);
    chk("acc_g1_v2", ov4, 1'b0);
    feed4(4);
    chk("acc_g1_valid", ov4, 1'b1);
    chk("acc_g1_data", o4, 16'd3);
    repeat (4) feed4(32767);
    chk("acc_max_valid", ov4, 1'b1);
    chk("acc_max_data", o4, 16'h7fff);
    repeat (4) feed4(-32768);
    chk("acc_min_valid", ov4, 1'b1);
    chk("acc_min_data", o4, 16'h8000);
    v4 = 1'b0;
    tick();
    chk("acc_drain", ov4, 1'b0);
`else
    // Pick stream 0..15, PHASE=1
    or4 = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      feed4(int'(i));
      if (i % 4 == 1) exp_last = 16'(i);
      chk("pick_rdy", rdy4, 1'b1);
      chk("pick_valid", ov4, (i % 4 == 1));
      chk("pick_data", o4, exp_last);
    end
    v4 = 1'b0;
    tick();
    chk("pick_drain", ov4, 1'b0);
`endif

    // Backpressure and simultaneous push/pop on DECIM=1
    or1 = 1'b0;
    v1 = 1'b1; s1 = 16'sd10;
    tick();
    chk("bp_v10", ov1, 1'b1);
    chk("bp_d10", o1, 16'd10);
    chk("bp_rdy1", rdy1, 1'b1);
    s1 = 16'sd20;
    tick();
    chk("bp_full_rdy", rdy1, 1'b0);
    chk("bp_head10", o1, 16'd10);
    s1 = 16'sd30;
    tick();
    chk("bp_stall_rdy", rdy1, 1'b0);
    chk("bp_stall_head", o1, 16'd10);
    or1 = 1'b1;
    tick();
    chk("bp_d20", o1, 16'd20);
    chk("bp_rdy_back", rdy1, 1'b1);
    tick();
    chk("pp_valid", ov1, 1'b1);
    chk("pp_d30", o1, 16'd30);
    v1 = 1'b0;
    tick();
    chk("bp_empty", ov1, 1'b0);
    chk("bp_hold30", o1, 16'd30);
    tick();
    chk("empty_pop_noop_v", ov1, 1'b0);
    chk("empty_pop_noop_d", o1, 16'd30);

`ifdef FIR_DECIM_ACC_DUMP_EN
    // phase_clr zeroes phase and accumulator; same-cycle input ignored
    or4 = 1'b0;
    feed4(100);
    feed4(100);
    v4 = 1'b1; s4 = 16'sd55; clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("aclr_valid", ov4, 1'b0);
    feed4(1);
    feed4(2);
    feed4(3);
    chk("aclr_v3", ov4, 1'b0);
    feed4(4);
    chk("aclr_valid2", ov4, 1'b1);
    chk("aclr_data", o4, 16'd3);
    or4 = 1'b1; v4 = 1'b0;
    tick();
    or4 = 1'b0;
    feed4(1000);
    feed4(1000);
    v4 = 1'b0;
`else
    // phase_clr with one FIFO entry after 2 of 4 samples
    or4 = 1'b0;
    feed4(100);
    feed4(101);
    chk("clr_pre_valid", ov4, 1'b1);
    chk("clr_pre_data", o4, 16'd101);
    v4 = 1'b1; s4 = 16'sd55; clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("clr_valid", ov4, 1'b0);
    chk("clr_rdy", rdy4, 1'b1);
    feed4(7);
    chk("clr_7_phase0", ov4, 1'b0);
    feed4(8);
    chk("clr_8_valid", ov4, 1'b1);
    chk("clr_8_data", o4, 16'd8);
    v4 = 1'b0; or4 = 1'b1;
    tick();
    chk("clr_drain", ov4, 1'b0);
`endif

    // Asynchronous reset mid-stream
    or1 = 1'b0;
    v1 = 1'b1; s1 = 16'sd77;
    tick();
    v1 = 1'b0;
    chk("mid_pre_v", ov1, 1'b1);
    chk("mid_pre_d", o1, 16'd77);
    #3 rst = 1'b0;
    #2;
    chk("mid_ov1", ov1, 1'b0);
    chk("mid_rdy1", rdy1, 1'b0);
    chk("mid_o1", o1, 16'd0);
    chk("mid_rdy4", rdy4, 1'b0);
    chk("mid_o4", o4, 16'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rel_rdy1", rdy1, 1'b0);
    tick();
    chk("mid_rdy1_up", rdy1, 1'b1);
    chk("mid_rdy4_up", rdy4, 1'b1);

    or4 = 1'b1;
`ifdef FIR_DECIM_ACC_DUMP_EN
    feed4(1);
    feed4(2);
    feed4(3);
    chk("post_acc_v3", ov4, 1'b0);
    feed4(4);
    chk("post_acc_valid", ov4, 1'b1);
    chk("post_acc_data", o4, 16'd3);
`else
    feed4(40);
    chk("post_pick_v40", ov4, 1'b0);
    feed4(41);
    chk("post_pick_valid", ov4, 1'b1);
    chk("post_pick_data", o4, 16'd41);
`endif
    v4 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the FIR filter: consumes the filtered 16-bit sample stream and decimates it by integer factor M.
- Keeps one sample in every M, and buffers kept samples in a 2-entry output FIFO.
- Uses the same valid/ready handshake on both sides, so it drops in directly after the filter and before the output sink.

Parameters:
- DECIM, default 4: decimation factor M; legal range 1..256.
- PHASE, default 0: index within each group of M input samples that is kept; legal range 0..DECIM-1.
- DW, default 16: sample width.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- phase_clr  in  1  synchronous clear: resets the phase counter to 0 and empties the FIFO.
- in_valid  in  1  upstream sample valid.
- in_sample  in  DW  upstream sample, signed two's complement.
- in_ready  out  1  block can accept an input sample this cycle.
- out_valid  out  1  out_sample holds a valid decimated sample.
- out_ready  in  1  downstream accepts out_sample this cycle.
- out_sample  out  DW  decimated sample, signed.

Behaviour:
- Reset (rst low, asynchronous), all values in force while rst is low:
  - phase counter = 0, FIFO count = 0, both FIFO entries = 0.
  - out_valid = 0, out_sample = 0, in_ready = 0.
  - in_ready rises on the first clock edge after rst deasserts.
- Input accept: occurs on a rising edge where in_valid && in_ready.
- in_ready = (count != 2). It is driven from registers only, with no combinational path from out_ready.
- Phase counter:
  - Advances on every accepted input, 0..DECIM-1.
  - Wraps from DECIM-1 back to 0.
- Keep rule:
  - An accepted sample is pushed into the FIFO iff the phase counter equals PHASE before the increment.
  - All other accepted samples are discarded.
- DECIM = 1: every accepted sample is kept and PHASE is ignored.
- FIFO:
  - 2 entries; head register drives out_sample directly.
  - out_valid = (count != 0).
  - Pop occurs when out_valid && out_ready.
- Latency: a kept sample accepted at edge N appears on out_sample/out_valid after edge N when the FIFO was empty; otherwise it appears behind the queued entries.
- Simultaneous push and pop:
  - count = 1: count stays 1 and the head takes the new sample.
  - count = 2: no push is possible because in_ready is low; a pop leaves count = 1.
- Empty FIFO with out_ready high: no effect; out_sample holds its last value.
- Full FIFO (count = 2): in_ready = 0, so upstream stalls. No sample is ever lost inside this block.
- phase_clr (synchronous):
  - On the next edge: phase = 0, count = 0, out_valid = 0.
  - Any input accepted in that same cycle is ignored.
  - Has priority over push and pop.
- Data is bit-exact in pick mode: out_sample equals the kept in_sample.
- Reset asserted mid-stream: all state is cleared immediately, including partially accumulated state.

Optional Feature:
- Macro: FIR_DECIM_ACC_DUMP_EN.
- With the macro defined (boxcar mode):
  - A (DW + log2(DECIM))-bit signed accumulator sums all DECIM samples of each group.
  - At the wrap, the sum is pushed, then the accumulator is cleared to 0.
  - Pushed value = sum shifted arithmetically right by log2(DECIM), rounding half up (add 2^(log2 DECIM - 1) before the shift), then saturated to the signed DW range.
  - DECIM must be a power of two; elaboration fails otherwise.
  - PHASE is ignored; the push occurs on the sample at phase DECIM-1.
  - phase_clr and reset also zero the accumulator.
- Without the macro: pick mode only, and no accumulator logic is generated.

Decomposition:
- Shared package fir_pkg holds:
  - sample width constant SAMPLE_W = 16.
  - signed sample typedef sample_t.
  - function clog2 used to size the phase counter and accumulator.
- One sub-module, fir_skid_fifo2: the 2-entry valid/ready FIFO (push, pop, count, head). It is reusable at the output of the filter itself.
- The phase counter and the keep/accumulate logic stay in fir_decimator.

Test Plan:
- Pick mode, DECIM=4, PHASE=1, out_ready=1, inputs 0..15 streamed every cycle -> outputs 1, 5, 9, 13, one cycle after each kept input; in_ready stays 1 throughout.
- Backpressure: out_ready=0, DECIM=1, inputs 10, 20, 30 offered back-to-back -> 10 and 20 accepted, in_ready=0 while 30 is held. Then out_ready=1 -> outputs 10, 20, 30 in order, with no loss and no duplicates.
- Simultaneous push/pop: count=1, out_ready=1, kept input present on the same edge -> count remains 1 and out_sample shows the new value the next cycle.
- phase_clr asserted after 2 of 4 samples, FIFO holding 1 entry -> next cycle out_valid=0, and the next input 0x7 is treated as phase 0.
- Reset mid-stream (rst low for 1 cycle, asynchronous to clk) -> out_valid and in_ready drop immediately, and all registers read 0.
- FIR_DECIM_ACC_DUMP_EN with DECIM=4:
  - inputs 1, 2, 3, 4 -> output 3 (10 + 2 = 12, 12 >> 2 = 3).
  - inputs 4 × 32767 -> output 32767 (saturated).
  - inputs 4 × -32768 -> output -32768.
